// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM pipeline control blocks.
package arm_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } pc_state_t;

   localparam logic [3:0] REG_PC       = 4'd15;
   localparam int         TIMEOUT_DFLT = 255;

endpackage

// File: rtl/pipeline_controller_if.sv
// Pipeline-facing signal bundle of the stall/flush controller.
interface pipeline_controller_if #(
   parameter int CNT_W = 32
);
   logic             forward_en;
   logic [3:0]       src1;
   logic [3:0]       src2;
   logic             Two_src;
   logic [3:0]       exe_dest;
   logic             exe_wb_en;
   logic             exe_mem_r_en;
   logic [3:0]       mem_dest;
   logic             mem_wb_en;
   logic             branch_taken;
   logic             mem_req;
   logic             sram_ready;
   logic             hazard;
   logic             freeze_pipe;
   logic             flush_if_id;
   logic             flush_id_exe;
   logic             mem_error;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output forward_en, src1, src2, Two_src, exe_dest, exe_wb_en, exe_mem_r_en,
             mem_dest, mem_wb_en, branch_taken, mem_req, sram_ready,
      input  hazard, freeze_pipe, flush_if_id, flush_id_exe, mem_error,
             stall_cycles, flush_count
   );

   modport slave (
      input  forward_en, src1, src2, Two_src, exe_dest, exe_wb_en, exe_mem_r_en,
             mem_dest, mem_wb_en, branch_taken, mem_req, sram_ready,
      output hazard, freeze_pipe, flush_if_id, flush_id_exe, mem_error,
             stall_cycles, flush_count
   );
endinterface

// File: rtl/pipeline_controller_hazard_detect.sv
// RAW hazard detection of ID operands against the EXE and MEM destinations.
// Purely combinational; with forwarding only a load in EXE can stall.
module hazard_detect (
   input  logic       forward_en_i,
   input  logic [3:0] src1_i,
   input  logic [3:0] src2_i,
   input  logic       two_src_i,
   input  logic [3:0] exe_dest_i,
   input  logic       exe_wb_en_i,
   input  logic       exe_mem_r_en_i,
   input  logic [3:0] mem_dest_i,
   input  logic       mem_wb_en_i,
   output logic       raw_o
);
   logic m1, m2, m3, m4;

   assign m1 = (src1_i == exe_dest_i) & exe_wb_en_i;
   assign m2 = two_src_i & (src2_i == exe_dest_i) & exe_wb_en_i;
   assign m3 = (src1_i == mem_dest_i) & mem_wb_en_i;
   assign m4 = two_src_i & (src2_i == mem_dest_i) & mem_wb_en_i;

   assign raw_o = forward_en_i ? ((m1 | m2) & exe_mem_r_en_i) : (m1 | m2 | m3 | m4);
endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush scheduler: memory freeze beats branch flush beats data hazard.
// Controls are combinational same-cycle; memory waits are bounded by TIMEOUT.
module pipeline_controller
   import arm_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DFLT,
   parameter int CNT_W   = 32
) (
   input logic                   clk,
   input logic                   rst,
   pipeline_controller_if.slave  pc
);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [7:0]       TO_CNT  = 8'(TIMEOUT);

   pc_state_t        state_q;
   logic [7:0]       wait_cnt_q;
   logic             mem_error_q;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   logic raw;
   logic timeout_hit;
   logic freeze_raw;
   logic freeze, flush, hazard;

   hazard_detect u_hazard_detect (
      .forward_en_i   (pc.forward_en),
      .src1_i         (pc.src1),
      .src2_i         (pc.src2),
      .two_src_i      (pc.Two_src),
      .exe_dest_i     (pc.exe_dest),
      .exe_wb_en_i    (pc.exe_wb_en),
      .exe_mem_r_en_i (pc.exe_mem_r_en),
      .mem_dest_i     (pc.mem_dest),
      .mem_wb_en_i    (pc.mem_wb_en),
      .raw_o          (raw)
   );

   // A ready SRAM always wins over the timeout in the same cycle.
   assign timeout_hit = (state_q == MEM_WAIT) & (wait_cnt_q == TO_CNT) & ~pc.sram_ready;
   assign freeze_raw  = pc.mem_req & ~pc.sram_ready & ~timeout_hit;

   assign freeze = ~rst & freeze_raw;
   assign flush  = ~rst & pc.branch_taken & ~freeze_raw;
   assign hazard = ~rst & raw & ~freeze_raw & ~pc.branch_taken;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         wait_cnt_q  <= 8'd0;
         mem_error_q <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (pc.mem_req & ~pc.sram_ready) begin
                  state_q    <= MEM_WAIT;
                  wait_cnt_q <= 8'd1;
               end else begin
                  wait_cnt_q <= 8'd0;
               end
            end
            MEM_WAIT: begin
               if (pc.sram_ready) begin
                  state_q    <= RUN;
                  wait_cnt_q <= 8'd0;
               end else if (timeout_hit) begin
                  state_q     <= RUN;
                  wait_cnt_q  <= 8'd0;
                  mem_error_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end
            default: begin
               state_q    <= RUN;
               wait_cnt_q <= 8'd0;
            end
         endcase
      end
   end

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if ((freeze | hazard) && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_ONE;
      if (flush && (flush_q != CNT_MAX))             flush_d = flush_q + CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign pc.hazard       = hazard;
   assign pc.freeze_pipe  = freeze;
   assign pc.flush_if_id  = flush;
   assign pc.flush_id_exe = flush;
   assign pc.mem_error    = mem_error_q;
   assign pc.stall_cycles = stall_q;
   assign pc.flush_count  = flush_q;
endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller with TIMEOUT=4 and 4-bit counters.
module tb_pipeline_controller;
   import arm_pkg::*;

   localparam int TO = 4;
   localparam int CW = 4;

   typedef struct {
      logic       fwd;
      logic [3:0] s1;
      logic [3:0] s2;
      logic       two;
      logic [3:0] ed;
      logic       ewb;
      logic       emr;
      logic [3:0] md;
      logic       mwb;
      logic       br;
      logic       mreq;
      logic       rdy;
      logic       e_haz;
      logic       e_frz;
      logic       e_fl;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   exp_stall;
   int   exp_flush;
   vec_t vecs[13];

   pipeline_controller_if #(.CNT_W(CW)) pif ();

   pipeline_controller #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .pc  (pif.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v);
      pif.forward_en   = v.fwd;
      pif.src1         = v.s1;
      pif.src2         = v.s2;
      pif.Two_src      = v.two;
      pif.exe_dest     = v.ed;
      pif.exe_wb_en    = v.ewb;
      pif.exe_mem_r_en = v.emr;
      pif.mem_dest     = v.md;
      pif.mem_wb_en    = v.mwb;
      pif.branch_taken = v.br;
      pif.mem_req      = v.mreq;
      pif.sram_ready   = v.rdy;
   endtask

   task automatic idle();
      vec_t v;
      v = '{1'b0, 4'd0, 4'd0, 1'b0, 4'd14, 1'b0, 1'b0, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      apply(v);
   endtask

   // Non-forwarding RAW on src1 against EXE.
   task automatic raw_on();
      pif.forward_en = 1'b0;
      pif.src1       = 4'd3;
      pif.exe_dest   = 4'd3;
      pif.exe_wb_en  = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic chk_ctl(input string name, input logic h, input logic f, input logic fl);
      chk({name, ".hazard"}, 32'(pif.hazard), 32'(h));
      chk({name, ".freeze"}, 32'(pif.freeze_pipe), 32'(f));
      chk({name, ".flush_if_id"}, 32'(pif.flush_if_id), 32'(fl));
      chk({name, ".flush_id_exe"}, 32'(pif.flush_id_exe), 32'(fl));
   endtask

   initial begin
      // fwd s1 s2 two ed ewb emr md mwb br mreq rdy | haz frz fl
      vecs[0]  = '{0, 3, 0, 0,  3, 1, 0, 13, 0, 0, 0, 0, 1, 0, 0};
      vecs[1]  = '{1, 0, 5, 1,  5, 1, 1, 13, 0, 0, 0, 0, 1, 0, 0};
      vecs[2]  = '{1, 0, 5, 1,  5, 1, 0, 13, 0, 0, 0, 0, 0, 0, 0};
      vecs[3]  = '{0, 0, 5, 0,  5, 1, 0, 13, 0, 0, 0, 0, 0, 0, 0};
      vecs[4]  = '{0, 7, 0, 0, 14, 0, 0,  7, 1, 0, 0, 0, 1, 0, 0};
      vecs[5]  = '{1, 7, 0, 0, 14, 0, 0,  7, 1, 0, 0, 0, 0, 0, 0};
      vecs[6]  = '{0, 0, 9, 1, 14, 0, 0,  9, 1, 0, 0, 0, 1, 0, 0};
      vecs[7]  = '{0, 3, 0, 0,  3, 0, 0, 13, 0, 0, 0, 0, 0, 0, 0};
      vecs[8]  = '{0, 3, 0, 0,  3, 1, 0, 13, 0, 1, 0, 0, 0, 0, 1};
      vecs[9]  = '{0, 3, 0, 0,  3, 1, 0, 13, 0, 0, 1, 1, 1, 0, 0};
      vecs[10] = '{0, 0, 0, 0, 14, 0, 0, 13, 0, 1, 1, 1, 0, 0, 1};
      vecs[11] = '{0, 0, 0, 0, 14, 0, 0, 13, 0, 0, 0, 0, 0, 0, 0};
      vecs[12] = '{1, 2, 2, 1,  2, 1, 1, 13, 0, 0, 0, 0, 1, 0, 0};

      // Outputs are forced low while reset is asserted, even with every cause active.
      idle();
      raw_on();
      pif.branch_taken = 1'b1;
      pif.mem_req      = 1'b1;
      rst = 1'b1;
      tick();
      #2;
      chk_ctl("in_reset", 1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      idle();
      #2;
      chk("reset.mem_error", 32'(pif.mem_error), 32'd0);
      chk("reset.stall", 32'(pif.stall_cycles), 32'd0);
      chk("reset.flush", 32'(pif.flush_count), 32'd0);
      chk("reset.state", 32'(dut.state_q), 32'(RUN));
      chk("reset.wait_cnt", 32'(dut.wait_cnt_q), 32'd0);

      // Single-cycle vectors, all staying in RUN.
      exp_stall = 0;
      exp_flush = 0;
      for (int i = 0; i < 13; i++) begin
         apply(vecs[i]);
         #2;
         chk_ctl($sformatf("vec%0d", i), vecs[i].e_haz, vecs[i].e_frz, vecs[i].e_fl);
         if (vecs[i].e_haz | vecs[i].e_frz) exp_stall++;
         if (vecs[i].e_fl) exp_flush++;
         tick();
      end
      idle();
      #2;
      chk("table.stall", 32'(pif.stall_cycles), 32'(exp_stall));
      chk("table.flush", 32'(pif.flush_count), 32'(exp_flush));
      chk("table.state", 32'(dut.state_q), 32'(RUN));

      // Memory wait of 4 cycles; ready arrives exactly when wait_cnt equals TIMEOUT.
      do_reset();
      idle();
      pif.mem_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk($sformatf("memwait.freeze%0d", i), 32'(pif.freeze_pipe), 32'd1);
         tick();
      end
      pif.sram_ready = 1'b1;
      #2;
      chk("memwait.ready_freeze", 32'(pif.freeze_pipe), 32'd0);
      tick();
      idle();
      #2;
      chk("memwait.state", 32'(dut.state_q), 32'(RUN));
      chk("memwait.stall", 32'(pif.stall_cycles), 32'd4);
      chk("memwait.no_error", 32'(pif.mem_error), 32'd0);

      // Branch held in EXE through a 3-cycle freeze, with a RAW pending.
      do_reset();
      idle();
      raw_on();
      pif.branch_taken = 1'b1;
      pif.mem_req      = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk_ctl($sformatf("brfrz%0d", i), 1'b0, 1'b1, 1'b0);
         tick();
      end
      pif.sram_ready = 1'b1;
      #2;
      chk_ctl("brfrz.release", 1'b0, 1'b0, 1'b1);
      tick();
      idle();
      #2;
      chk("brfrz.flush", 32'(pif.flush_count), 32'd1);
      chk("brfrz.stall", 32'(pif.stall_cycles), 32'd3);

      // Timeout: SRAM never answers.
      do_reset();
      idle();
      pif.mem_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk($sformatf("timeout.freeze%0d", i), 32'(pif.freeze_pipe), 32'd1);
         tick();
      end
      #2;
      chk("timeout.release", 32'(pif.freeze_pipe), 32'd0);
      chk("timeout.err_before", 32'(pif.mem_error), 32'd0);
      tick();
      idle();
      pif.branch_taken = 1'b1;
      #2;
      chk("timeout.err_set", 32'(pif.mem_error), 32'd1);
      chk("timeout.state", 32'(dut.state_q), 32'(RUN));
      tick();
      idle();
      tick();
      tick();
      #2;
      chk("timeout.err_held", 32'(pif.mem_error), 32'd1);
      chk("timeout.stall", 32'(pif.stall_cycles), 32'd4);
      chk("timeout.flush", 32'(pif.flush_count), 32'd1);
      do_reset();
      #2;
      chk("timeout.err_cleared", 32'(pif.mem_error), 32'd0);
      chk("timeout.stall_cleared", 32'(pif.stall_cycles), 32'd0);
      chk("timeout.flush_cleared", 32'(pif.flush_count), 32'd0);

      // Reset while waiting on memory abandons the access.
      pif.mem_req = 1'b1;
      tick();
      tick();
      chk("rstwait.in_wait", 32'(dut.state_q), 32'(MEM_WAIT));
      rst = 1'b1;
      #2;
      chk("rstwait.freeze_in_rst", 32'(pif.freeze_pipe), 32'd0);
      tick();
      rst = 1'b0;
      idle();
      #2;
      chk("rstwait.state", 32'(dut.state_q), 32'(RUN));
      chk("rstwait.wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
      chk("rstwait.freeze", 32'(pif.freeze_pipe), 32'd0);

      // Stall counter saturation.
      do_reset();
      idle();
      raw_on();
      for (int i = 0; i < 20; i++) begin
         if (i == 14) chk("sat.at14", 32'(pif.stall_cycles), 32'd14);
         tick();
      end
      #2;
      chk("sat.hazard", 32'(pif.hazard), 32'd1);
      chk("sat.stall", 32'(pif.stall_cycles), 32'd15);
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
